// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RISC-V pipeline.
// ALU results pass straight through. Loads and stores run a byte-serial
// request/acknowledge transaction on the data-memory port while stall_req
// holds the upstream stages. Loads are assembled little-endian, then sign-
// or zero-extended.
//
// Data-memory handshake: dmem_req is the valid. While it is high, dmem_addr,
// dmem_rw and dmem_wbyte stay stable. A byte completes on a rising edge where
// dmem_req and dmem_ack are both high. dmem_ack is ignored while dmem_req is
// low, and dmem_rbyte is only sampled alongside an accepted ack.
module mem_access_stage #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
    input  logic                  mem_we,
    input  logic [31:0]           mem_reg_wdata,
    input  logic [3:0]            mem_op,
    input  logic [31:0]           mem_store_data,
    output logic                  dmem_req,
    output logic                  dmem_rw,
    output logic [31:0]           dmem_addr,
    output logic [7:0]            dmem_wbyte,
    input  logic [7:0]            dmem_rbyte,
    input  logic                  dmem_ack,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] wb_reg_waddr,
    output logic                  wb_we,
    output logic [31:0]           wb_reg_wdata,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            cnt_q;
    logic [2:0]            len_q;
    logic [3:0]            op_q;
    logic [31:0]           base_q;
    logic [31:0]           sdata_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic                  we_q;
    logic [31:0]           asm_q;
    logic [31:0]           load_ext;

    // Codes 1..8 touch memory; 9..15 behave like NOP/ALU.
    function automatic logic is_mem(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // Number of bytes moved by a memory op.
    function automatic logic [2:0] op_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 3'd1;
            4'd2, 4'd5, 4'd7: return 3'd2;
            default:          return 3'd4;
        endcase
    endfunction

    // Transaction FSM: capture in IDLE, one byte per ack in BUSY, and a single
    // DONE cycle that never recaptures the op still sitting in EX/MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            len_q   <= 3'd0;
            op_q    <= 4'd0;
            base_q  <= 32'd0;
            sdata_q <= 32'd0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            asm_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mem(mem_op)) begin
                        cnt_q   <= 2'd0;
                        len_q   <= op_len(mem_op);
                        op_q    <= mem_op;
                        base_q  <= mem_reg_wdata;
                        sdata_q <= mem_store_data;
                        waddr_q <= mem_reg_waddr;
                        we_q    <= mem_we;
                        asm_q   <= 32'd0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        if (!is_store(op_q)) begin
                            asm_q[{cnt_q, 3'b000} +: 8] <= dmem_rbyte;
                        end
                        if ({1'b0, cnt_q} == (len_q - 3'd1)) begin
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sign/zero extension of the assembled load value.
    always_comb begin
        load_ext = asm_q;
        case (op_q)
            4'd1:    load_ext = {{24{asm_q[7]}}, asm_q[7:0]};
            4'd2:    load_ext = {{16{asm_q[15]}}, asm_q[15:0]};
            4'd4:    load_ext = {24'd0, asm_q[7:0]};
            4'd5:    load_ext = {16'd0, asm_q[15:0]};
            default: load_ext = asm_q;
        endcase
    end

    // Output decode from state; everything is forced low during reset.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_rw      = 1'b0;
        dmem_addr    = 32'd0;
        dmem_wbyte   = 8'd0;
        stall_req    = 1'b0;
        wb_reg_waddr = '0;
        wb_we        = 1'b0;
        wb_reg_wdata = 32'd0;
        dbg_state_o  = 2'd0;
        if (!rst) begin
            dbg_state_o = state_q;
            case (state_q)
                S_IDLE: begin
                    if (is_mem(mem_op)) begin
                        stall_req = 1'b1;
                    end else begin
                        wb_reg_waddr = mem_reg_waddr;
                        wb_we        = mem_we;
                        wb_reg_wdata = mem_reg_wdata;
                    end
                end
                S_BUSY: begin
                    dmem_req   = 1'b1;
                    dmem_rw    = is_store(op_q);
                    dmem_addr  = base_q + {30'd0, cnt_q};
                    dmem_wbyte = sdata_q[{cnt_q, 3'b000} +: 8];
                    stall_req  = 1'b1;
                end
                S_DONE: begin
                    if (!is_store(op_q)) begin
                        wb_we        = we_q;
                        wb_reg_waddr = waddr_q;
                        wb_reg_wdata = load_ext;
                    end
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: an EX/MEM driver, a byte-level memory
// responder and a write-back monitor, each checked against a reference
// memory and expected queues built by the driver.
module tb_mem_access_stage;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_reg_waddr;
    logic          mem_we;
    logic [31:0]   mem_reg_wdata;
    logic [3:0]    mem_op;
    logic [31:0]   mem_store_data;
    logic          dmem_req;
    logic          dmem_rw;
    logic [31:0]   dmem_addr;
    logic [7:0]    dmem_wbyte;
    logic [7:0]    dmem_rbyte;
    logic          dmem_ack;
    logic          stall_req;
    logic [AW-1:0] wb_reg_waddr;
    logic          wb_we;
    logic [31:0]   wb_reg_wdata;
    logic [1:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [37:0] exp_q[$];   // {waddr, we, wdata}
    logic [40:0] bus_q[$];   // {rw, addr, wbyte}
    logic [7:0]  ref_mem[logic [31:0]];
    logic [7:0]  bus_mem[logic [31:0]];

    int wait_left   = 0;
    bit rand_waits  = 1'b0;
    int total_waits = 0;

    mem_access_stage #(.REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we),
        .mem_reg_wdata(mem_reg_wdata), .mem_op(mem_op),
        .mem_store_data(mem_store_data),
        .dmem_req(dmem_req), .dmem_rw(dmem_rw), .dmem_addr(dmem_addr),
        .dmem_wbyte(dmem_wbyte), .dmem_rbyte(dmem_rbyte), .dmem_ack(dmem_ack),
        .stall_req(stall_req),
        .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
        .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int op_len(input int op);
        case (op)
            1, 4, 6: return 1;
            2, 5, 7: return 2;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ref_mem[a] = b;
        bus_mem[a] = b;
    endtask

    // Driver: presents one op from EX/MEM and holds it until the stage
    // releases stall; the expected write-back and bus bytes are queued first.
    task automatic issue(input int op, input logic [AW-1:0] wa, input logic we,
                         input logic [31:0] wd, input logic [31:0] sd);
        logic [31:0] a;
        logic [31:0] val;
        logic [7:0]  b;
        int          len;
        int          exp_cyc;
        int          cyc;
        int          w0;
        if (op >= 1 && op <= 8) begin
            len = op_len(op);
            exp_cyc = 2 + len;
            val = 32'd0;
            for (int i = 0; i < len; i++) begin
                a = wd + 32'(i);
                if (op >= 6) begin
                    b = 8'((sd >> (8 * i)) & 32'hFF);
                    ref_mem[a] = b;
                    bus_q.push_back({1'b1, a, b});
                end else begin
                    bus_q.push_back({1'b0, a, 8'h00});
                    val = val + (32'(ref_rd(a)) << (8 * i));
                end
            end
            if (op >= 6) begin
                exp_q.push_back({wa, 1'b0, 32'd0});
            end else begin
                if (op == 1 && val >= 32'h80)   val = val + 32'hFFFFFF00;
                if (op == 2 && val >= 32'h8000) val = val + 32'hFFFF0000;
                exp_q.push_back({wa, we, val});
            end
        end else begin
            exp_cyc = 1;
            exp_q.push_back({wa, we, wd});
        end
        mem_op         = 4'(op);
        mem_reg_waddr  = wa;
        mem_we         = we;
        mem_reg_wdata  = wd;
        mem_store_data = sd;
        w0  = total_waits;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (stall_req && cyc < 100);
        check($sformatf("latency_op%0d", op), 64'(cyc), 64'(exp_cyc + (total_waits - w0)));
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks bytes with optional wait cycles and checks each
    // completed byte against the expected bus sequence.
    always @(negedge clk) begin
        logic [40:0] e;
        if (!rst && dmem_req) begin
            if (wait_left > 0) begin
                dmem_ack = 1'b0;
                wait_left--;
                total_waits++;
            end else begin
                dmem_ack = 1'b1;
                if (bus_q.size() == 0) begin
                    check("bus_extra_byte", 64'(dmem_addr), 64'(0));
                    if (dmem_addr == 32'd0) begin
                        errors++;
                        $display("FAIL bus_extra_byte actual=req expected=no_req");
                    end
                end else begin
                    e = bus_q.pop_front();
                    check("bus_rw", 64'(dmem_rw), 64'(e[40]));
                    check("bus_addr", 64'(dmem_addr), 64'(e[39:8]));
                    if (e[40]) check("bus_wbyte", 64'(dmem_wbyte), 64'(e[7:0]));
                end
                if (dmem_rw) bus_mem[dmem_addr] = dmem_wbyte;
                dmem_rbyte = bus_mem.exists(dmem_addr) ? bus_mem[dmem_addr] : init_byte(dmem_addr);
                wait_left = rand_waits ? int'($urandom_range(0, 2)) : 0;
            end
        end else begin
            dmem_ack   = 1'b0;
            dmem_rbyte = 8'($urandom);
        end
    end

    // Write-back monitor: every cycle the stage is not stalling it hands a
    // result to MEM/WB, which must match the head of the expected queue.
    always @(negedge clk) begin
        logic [37:0] e;
        if (!rst && !stall_req) begin
            check("req_when_not_stalled", 64'(dmem_req), 64'(0));
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL wb_unexpected actual=we%0d/%0h expected=none", wb_we, wb_reg_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wb_we", 64'(wb_we), 64'(e[32]));
                check("wb_wdata", 64'(wb_reg_wdata), 64'(e[31:0]));
                if (e[32]) check("wb_waddr", 64'(wb_reg_waddr), 64'(e[37:33]));
            end
        end
    end

    initial begin
        logic [31:0] ra;
        int          op;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rbyte = 8'd0;
        mem_op = 4'd3;
        mem_reg_waddr = 5'd9;
        mem_we = 1'b1;
        mem_reg_wdata = 32'h100;
        mem_store_data = 32'hDEADBEEF;

        // Reset holds every output low even with a memory op presented.
        repeat (2) begin
            @(negedge clk);
            check("rst_bus", 64'({dmem_req, dmem_rw, dmem_addr, dmem_wbyte}), 64'(0));
            check("rst_wb", 64'({stall_req, wb_we, wb_reg_waddr, wb_reg_wdata, dbg_state_o}), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU pass-through
        issue(0, 5'd5, 1'b1, 32'h1234, 32'd0);
        issue(12, 5'd17, 1'b0, 32'hCAFE0001, 32'd0);

        // LW with immediate acks
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        issue(3, 5'd7, 1'b1, 32'h100, 32'd0);

        // LB / LBU of 0x80
        poke(32'h200, 8'h80);
        issue(1, 5'd8, 1'b1, 32'h200, 32'd0);
        issue(4, 5'd9, 1'b1, 32'h200, 32'd0);

        // LH of 0x8001 with two wait cycles on the first byte
        poke(32'h300, 8'h01); poke(32'h301, 8'h80);
        wait_left = 2;
        issue(2, 5'd10, 1'b1, 32'h300, 32'd0);

        // SH wrapping the address space, then read it back
        issue(7, 5'd11, 1'b1, 32'hFFFFFFFF, 32'hAABBCCDD);
        issue(5, 5'd12, 1'b1, 32'hFFFFFFFF, 32'd0);

        // Reset in the middle of an LW after two acks
        for (int i = 0; i < 4; i++) bus_q.push_back({1'b0, 32'h100 + 32'(i), 8'h00});
        mem_op = 4'd3; mem_reg_waddr = 5'd3; mem_we = 1'b1; mem_reg_wdata = 32'h100;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        mem_op = 4'd0;
        @(negedge clk);
        check("midrst_bytes_left", 64'(bus_q.size()), 64'(2));
        check("midrst_bus", 64'({dmem_req, dmem_rw, dmem_addr, dmem_wbyte}), 64'(0));
        check("midrst_wb", 64'({stall_req, wb_we, wb_reg_waddr, wb_reg_wdata}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_q.delete();
        wait_left = 0;
        issue(0, 5'd1, 1'b1, 32'h55, 32'd0);
        issue(4, 5'd13, 1'b1, 32'h103, 32'd0);

        // Back-to-back: LW, SB, LW
        issue(3, 5'd14, 1'b1, 32'h100, 32'd0);
        issue(6, 5'd15, 1'b0, 32'h101, 32'h00000099);
        issue(3, 5'd16, 1'b1, 32'h100, 32'd0);

        // Randomized mix with random wait states
        rand_waits = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else ra = 32'h400 + 32'($urandom_range(0, 15));
            if (op == 0 || op > 8) ra = $urandom;
            issue(op, 5'($urandom), 1'($urandom), ra, $urandom);
        end
        rand_waits = 1'b0;

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        check("bus_q_drained", 64'(bus_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
